// File: rtl/memory_read_responder.sv
// Single-port read responder: one outstanding read with fixed latency, a
// broadcast copy of each response for snooping caches, and a program-load write port.
module memory_read_responder #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
  output logic                         mem_ready,
  output logic [MEMORY_WIDTH-1:0]      mem_data,
  output logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr,
  output logic                         broadcast_valid,
  input  logic                         wr_en,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic [31:0]                  req_count,
  output logic [1:0]                   o_dbg_state
);

  // Handshake: a request is taken on a rising edge where mem_valid=1 and the
  // responder is IDLE (and armed); mem_ready is a single-cycle completion pulse.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam int          DEPTH   = 2 ** MEMORY_ADDR_WIDTH;
  localparam logic [3:0]  LAT_M1  = 4'(READ_LATENCY - 1);
  localparam bit          LAT_ONE = (READ_LATENCY == 1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
      $error("memory_read_responder: READ_LATENCY must be within 1..15");
    end
  endgenerate

  logic [MEMORY_WIDTH-1:0]      r_mem [0:DEPTH-1];
  logic [MEMORY_WIDTH-1:0]      r_word;
  logic [1:0]                   r_state;
  logic [3:0]                   r_cnt;
  logic                         r_armed;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
  logic                         r_ready;
  logic                         r_bvalid;
  logic [MEMORY_WIDTH-1:0]      r_data;
  logic [MEMORY_ADDR_WIDTH-1:0] r_baddr;
  logic [31:0]                  r_count;

  logic [1:0]                   w_state_nxt;
  logic                         w_accept;
  logic                         w_to_respond;
  logic [MEMORY_WIDTH-1:0]      w_rd_word;

  // r_armed blocks acceptance on the first edge after reset release.
  assign w_accept     = (r_state == S_IDLE) && r_armed && mem_valid;
  assign w_to_respond = (w_accept && LAT_ONE) || ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_rd_word    = r_mem[mem_addr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = LAT_ONE ? S_RESPOND : S_WAIT;
      S_WAIT:    if (r_cnt == 4'd1) w_state_nxt = S_RESPOND;
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Array is never reset; non-blocking write makes same-cycle reads return the old word.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (w_accept) r_word <= w_rd_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_armed  <= 1'b0;
      r_addr   <= '0;
      r_ready  <= 1'b0;
      r_bvalid <= 1'b0;
      r_data   <= '0;
      r_baddr  <= '0;
      r_count  <= 32'd0;
    end else begin
      r_armed  <= 1'b1;
      r_state  <= w_state_nxt;
      if (w_accept) begin
        r_addr <= mem_addr;
        r_cnt  <= LAT_M1;
      end else if (r_state == S_WAIT) begin
        r_cnt  <= r_cnt - 4'd1;
      end
      r_ready  <= w_to_respond;
      r_bvalid <= w_to_respond;
      // With unit latency the response leaves straight from the accepting cycle.
      if (w_to_respond) begin
        r_data  <= (r_state == S_IDLE) ? w_rd_word : r_word;
        r_baddr <= (r_state == S_IDLE) ? mem_addr : r_addr;
      end
      if ((r_state == S_RESPOND) && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
    end
  end

  assign mem_ready       = r_ready;
  assign broadcast_valid = r_bvalid;
  assign mem_data        = r_data;
  assign broadcast_addr  = r_baddr;
  assign req_count       = r_count;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_memory_read_responder.sv
// Bench for memory_read_responder: a READ_LATENCY=2 and a READ_LATENCY=1 instance
// share stimulus and are compared every cycle against a timing-based reference model.
module tb_memory_read_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [10:0] mem_addr = '0;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic        a_ready, a_bvalid, b_ready, b_bvalid;
  logic [15:0] a_data, b_data;
  logic [10:0] a_baddr, b_baddr;
  logic [31:0] a_cnt, b_cnt;
  logic [1:0]  a_dbg, b_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  memory_read_responder #(.READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(a_ready), .mem_data(a_data), .broadcast_addr(a_baddr),
    .broadcast_valid(a_bvalid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .req_count(a_cnt), .o_dbg_state(a_dbg)
  );

  memory_read_responder #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(b_ready), .mem_data(b_data), .broadcast_addr(b_baddr),
    .broadcast_valid(b_bvalid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .req_count(b_cnt), .o_dbg_state(b_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Time-based view: a read accepted on edge a responds on edge a+L-1, and the
  // responder is free again from edge a+L+1. Index 0 is L=2, index 1 is L=1.
  logic [15:0] mem_m [0:2047];
  int          edge_n = 0;
  bit          m_armed [2];
  bit          m_pend  [2];
  int          m_resp  [2];
  int          m_free  [2];
  logic [15:0] m_pdata [2];
  logic [10:0] m_paddr [2];
  bit          e_ready [2];
  logic [15:0] e_data  [2];
  logic [10:0] e_baddr [2];
  logic [31:0] e_cnt   [2];

  task automatic model_step(input int i, input int lat);
    if (!rst) begin
      m_armed[i] = 0; m_pend[i] = 0; m_free[i] = 0;
      e_ready[i] = 0; e_data[i] = '0; e_baddr[i] = '0; e_cnt[i] = '0;
    end else begin
      if (e_ready[i] && e_cnt[i] != 32'hFFFF_FFFF) e_cnt[i] = e_cnt[i] + 1;
      if (m_armed[i] && mem_valid && edge_n >= m_free[i]) begin
        m_pend[i]  = 1;
        m_resp[i]  = edge_n + lat - 1;
        m_pdata[i] = mem_m[mem_addr];
        m_paddr[i] = mem_addr;
        m_free[i]  = edge_n + lat + 1;
      end
      m_armed[i] = 1;
      e_ready[i] = m_pend[i] && (edge_n == m_resp[i]);
      if (e_ready[i]) begin
        e_data[i]  = m_pdata[i];
        e_baddr[i] = m_paddr[i];
        m_pend[i]  = 0;
      end
    end
  endtask

  task automatic cmp_inst(input string tag, input int i, input logic r, input logic bv,
                          input logic [15:0] d, input logic [10:0] ba, input logic [31:0] c);
    check({tag, "_mem_ready"}, 32'(r), 32'(e_ready[i]));
    check({tag, "_bcast_valid"}, 32'(bv), 32'(e_ready[i]));
    check({tag, "_mem_data"}, 32'(d), 32'(e_data[i]));
    check({tag, "_bcast_addr"}, 32'(ba), 32'(e_baddr[i]));
    check({tag, "_req_count"}, c, e_cnt[i]);
  endtask

  // Compare process: model advances on each rising edge, outputs sampled 2 later.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      model_step(0, 2);
      model_step(1, 1);
      if (wr_en) mem_m[wr_addr] = wr_data;
      #2;
      cmp_inst("lat2", 0, a_ready, a_bvalid, a_data, a_baddr, a_cnt);
      cmp_inst("lat1", 1, b_ready, b_bvalid, b_data, b_baddr, b_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic after_edge();
    @(posedge clk); #3;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      wr_en     = 1'b0;
    end
  endtask

  task automatic pulse_read(input logic [10:0] a);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_ready", 32'(a_ready), 32'd0);
    check("reset_data", 32'(a_data), 32'd0);
    check("reset_count", a_cnt, 32'd0);

    // Preload addresses 0..31 (writes work while reset is held).
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 11'(i);
      case (i)
        1:       wr_data = 16'h0101;
        2:       wr_data = 16'h0202;
        5:       wr_data = 16'hBEEF;
        7:       wr_data = 16'h2222;
        9:       wr_data = 16'h0909;
        10:      wr_data = 16'h0A0A;
        default: wr_data = 16'($urandom);
      endcase
    end

    // Release reset with valid already held on addr 5: first edge must not accept.
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1; mem_valid = 1'b1; mem_addr = 11'd5;
    after_edge();
    check("first_edge_no_accept", 32'(b_ready), 32'd0);
    after_edge();
    check("lat1_ready_at_accept", 32'(b_ready), 32'd1);
    check("lat1_data_beef", 32'(b_data), 32'hBEEF);
    check("lat2_not_yet_ready", 32'(a_ready), 32'd0);
    after_edge();
    check("lat2_ready_after_2", 32'(a_ready), 32'd1);
    check("lat2_bvalid", 32'(a_bvalid), 32'd1);
    check("lat2_data_beef", 32'(a_data), 32'hBEEF);
    check("lat2_baddr_5", 32'(a_baddr), 32'd5);
    idle(4);

    // Same-cycle write and read of addr 7 returns the old word.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 11'd7;
    wr_en = 1'b1; wr_addr = 11'd7; wr_data = 16'h1111;
    after_edge();
    check("lat1_read_first", 32'(b_data), 32'h2222);
    @(negedge clk);
    mem_valid = 1'b0; wr_en = 1'b0;
    after_edge();
    check("lat2_read_first", 32'(a_data), 32'h2222);
    idle(3);
    pulse_read(11'd7);
    idle(4);
    check("lat2_new_word", 32'(a_data), 32'h1111);
    check("lat1_new_word", 32'(b_data), 32'h1111);

    // Address change and valid drop after acceptance are ignored.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 11'd9;
    @(negedge clk);
    mem_valid = 1'b0; mem_addr = 11'd10;
    idle(4);
    check("lat2_orig_addr_data", 32'(a_data), 32'h0909);
    check("lat2_orig_addr", 32'(a_baddr), 32'd9);
    check("lat1_orig_addr_data", 32'(b_data), 32'h0909);

    // Reset while lat2 instance is in WAIT.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 11'd5;
    @(negedge clk);
    mem_valid = 1'b0; rst = 1'b0;
    #1;
    check("rst_wait_ready", 32'(a_ready), 32'd0);
    check("rst_wait_data", 32'(a_data), 32'd0);
    check("rst_wait_baddr", 32'(a_baddr), 32'd0);
    check("rst_wait_count", a_cnt, 32'd0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    check("rst_no_late_resp", 32'(a_data), 32'd0);
    check("rst_no_late_count", a_cnt, 32'd0);
    pulse_read(11'd5);
    idle(4);
    check("array_preserved", 32'(a_data), 32'hBEEF);

    // Back-to-back reads of addr 1 then 2 with valid held.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 11'd1;
    after_edge();
    check("b2b_lat1_first", 32'(b_data), 32'h0101);
    @(negedge clk);
    mem_addr = 11'd2;
    after_edge();
    check("b2b_lat2_pulse1", 32'(a_ready), 32'd1);
    check("b2b_lat2_data1", 32'(a_data), 32'h0101);
    after_edge();
    check("b2b_lat2_gap1", 32'(a_ready), 32'd0);
    check("b2b_lat1_second", 32'(b_data), 32'h0202);
    after_edge();
    check("b2b_lat2_gap2", 32'(a_ready), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    after_edge();
    check("b2b_lat2_pulse2", 32'(a_ready), 32'd1);
    check("b2b_lat2_data2", 32'(a_data), 32'h0202);
    idle(3);
    check("b2b_lat2_count", a_cnt, 32'd3);
    check("b2b_lat1_count", b_cnt, 32'd3);

    // Randomized traffic with interleaved writes and occasional resets.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_addr  = 11'($urandom_range(0, 31));
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_addr   = 11'($urandom_range(0, 31));
      wr_data   = 16'($urandom);
      rst       = ($urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
